// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory model and wait-state timer.
package main_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;

endpackage

// File: rtl/main_mem_ctl_if.sv
// Cache-FSM <-> main-memory request/response bundle.
// ProtoErr is present only when MAIN_MEM_PROTOCOL_CHECK_EN is defined.
interface main_mem_ctl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();

    logic              LdCtr;
    logic              MStrobe;
    logic              MRW;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MDataIn;
    logic [DATA_W-1:0] MDataOut;
    logic              CtrSig;
    logic              Busy;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
    logic              ProtoErr;

    modport master (
        output LdCtr, MStrobe, MRW, MAddr, MDataIn,
        input  MDataOut, CtrSig, Busy, ProtoErr
    );

    modport slave (
        input  LdCtr, MStrobe, MRW, MAddr, MDataIn,
        output MDataOut, CtrSig, Busy, ProtoErr
    );
`else
    modport master (
        output LdCtr, MStrobe, MRW, MAddr, MDataIn,
        input  MDataOut, CtrSig, Busy
    );

    modport slave (
        input  LdCtr, MStrobe, MRW, MAddr, MDataIn,
        output MDataOut, CtrSig, Busy
    );
`endif

endinterface

// File: rtl/main_mem_ctl_wait_counter.sv
// Wait-state down-counter: reload on LdCtr, otherwise count down and hold at zero.
module wait_counter #(
    parameter int unsigned LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic LdCtr,
    output logic zero
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LOAD;
        end else if (LdCtr) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/main_mem_ctl.sv
// Main-memory model with fixed-latency completion handshake for the cache FSM.
// Optional build macro: MAIN_MEM_PROTOCOL_CHECK_EN adds the sticky ProtoErr flag.
module main_mem_ctl
    import main_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic           clk,
    input  logic           reset,
    main_mem_ctl_if.slave  bus
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              op_q;
    logic              busy_q;
    logic [DATA_W-1:0] dout_q;
    logic              zero;
    logic              ctr_sig_c;

    logic [DATA_W-1:0] mem [DEPTH];

    wait_counter #(
        .LATENCY (LATENCY)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .LdCtr (bus.LdCtr),
        .zero  (zero)
    );

    // Completion only counts inside an access; a reload in the same cycle defers it.
    assign ctr_sig_c = (state == ACCESS) && zero && !bus.LdCtr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            op_q   <= MRW_READ;
            busy_q <= 1'b0;
            dout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MStrobe) begin
                        addr_q <= bus.MAddr;
                        data_q <= bus.MDataIn;
                        op_q   <= bus.MRW;
                        busy_q <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ctr_sig_c) begin
                        if (op_q == MRW_READ) begin
                            dout_q <= mem[addr_q];
                        end
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; a reset in the completion cycle drops the write.
    always_ff @(posedge clk) begin
        if (!reset && ctr_sig_c && (op_q == MRW_WRITE)) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.MDataOut = dout_q;
    assign bus.CtrSig   = ctr_sig_c;
    assign bus.Busy     = busy_q;

`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
    logic proto_err_q;

    // Flags a strobe mid-access, or a strobe in IDLE without a counter load.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else if (bus.MStrobe && ((state == ACCESS) || !bus.LdCtr)) begin
            proto_err_q <= 1'b1;
        end
    end

    assign bus.ProtoErr = proto_err_q;
`endif

endmodule

// File: tb/tb_main_mem_ctl.sv
// Scoreboard bench for main_mem_ctl: random accesses against an array model,
// plus a LATENCY=1 instance exercised with back-to-back reads.
module tb_main_mem_ctl;

    localparam int L  = 4;
    localparam int L1 = 1;

    typedef struct {
        int         comp;
        bit         rd;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    int   n_chk  = 0;
    int   n_fail = 0;

    exp_t       sbq[$];
    logic [7:0] model_mem [256];
    bit         known [256];
    logic [7:0] exp_dout;
    bit         exp_busy;
    bit         mon_en;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
    bit         exp_proto;
    bit         stray_now;
`endif

    main_mem_ctl_if #(.ADDR_W(8), .DATA_W(8)) m  ();
    main_mem_ctl_if #(.ADDR_W(8), .DATA_W(8)) m1 ();

    main_mem_ctl #(.ADDR_W(8), .DATA_W(8), .LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    main_mem_ctl #(.ADDR_W(8), .DATA_W(8), .LATENCY(L1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (m1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each completion.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(m.Busy), 32'(exp_busy));
            chk("mdataout", 32'(m.MDataOut), 32'(exp_dout));
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
            chk("proto_err", 32'(m.ProtoErr), 32'(exp_proto));
            exp_proto = exp_proto | stray_now;
`endif
            if (m.CtrSig === 1'b1) begin
                chk("ctrsig_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ctrsig_cycle", 32'(cyc), 32'(e.comp));
                    if (e.rd) exp_dout = e.data;
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].comp) begin
                exp_t e;
                e = sbq.pop_front();
                chk("ctrsig_missed", 32'(m.CtrSig), 32'd1);
            end
        end
    end

    // One request: optional counter reload at offset r, optional stray strobe at offset s.
    task automatic access(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          input int r, input int s);
        int   c;
        int   comp;
        exp_t e;
        @(posedge clk); #1;
        c = cyc;
        m.MStrobe = 1'b1; m.LdCtr = 1'b1; m.MRW = wr; m.MAddr = addr; m.MDataIn = data;
        exp_busy = 1'b0;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
        stray_now = 1'b0;
`endif
        comp = c + L + r;
        e.comp = comp; e.rd = !wr; e.data = model_mem[addr];
        sbq.push_back(e);
        if (wr) begin
            model_mem[addr] = data;
            known[addr] = 1'b1;
        end
        for (int k = 1; k <= comp - c; k++) begin
            @(posedge clk); #1;
            m.MStrobe = (k == s);
            m.LdCtr   = (r != 0) && (k == r);
            m.MAddr   = (k == s) ? 8'($urandom_range(255)) : addr;
            m.MDataIn = (k == s) ? 8'($urandom_range(255)) : data;
            m.MRW     = (k == s) ? 1'($urandom_range(1)) : wr;
            exp_busy  = 1'b1;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
            stray_now = (k == s);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            m.MStrobe = 1'b0;
            m.LdCtr   = 1'($urandom_range(1));
            exp_busy  = 1'b0;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
            stray_now = 1'b0;
`endif
        end
    endtask

    // Write aborted by reset in its second wait cycle.
    task automatic reset_mid(input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        m.MStrobe = 1'b1; m.LdCtr = 1'b1; m.MRW = 1'b1; m.MAddr = addr; m.MDataIn = data;
        exp_busy = 1'b0;
        @(posedge clk); #1;
        m.MStrobe = 1'b0; m.LdCtr = 1'b0;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_busy = 1'b0;
        exp_dout = 8'h00;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
        exp_proto = 1'b0;
`endif
    endtask

    initial begin
        logic [7:0] a1 [4];
        logic [7:0] d1 [4];
        bit         w1 [4];
        logic [7:0] r1 [4];
        bit         wr;
        logic [7:0] addr;
        int         r;
        int         s;

        a1 = '{8'h10, 8'h20, 8'h10, 8'h20};
        d1 = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        w1 = '{1'b1, 1'b1, 1'b0, 1'b0};
        r1 = '{8'h00, 8'h00, 8'h5A, 8'hC3};

        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        exp_dout = 8'h00; exp_busy = 1'b0; mon_en = 1'b0;
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
        exp_proto = 1'b0; stray_now = 1'b0;
`endif
        m.MStrobe = 1'b0; m.LdCtr = 1'b0; m.MRW = 1'b0; m.MAddr = '0; m.MDataIn = '0;
        m1.MStrobe = 1'b0; m1.LdCtr = 1'b0; m1.MRW = 1'b0; m1.MAddr = '0; m1.MDataIn = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ctrsig", 32'(m.CtrSig), 32'd0);
        chk("reset_busy", 32'(m.Busy), 32'd0);
        chk("reset_dout", 32'(m.MDataOut), 32'd0);
        mon_en = 1'b1;

        // Directed: read timing, write-then-read, stray strobe, restart, reset abort.
        access(1'b1, 8'h12, 8'hA5, 0, 0);
        access(1'b0, 8'h12, 8'h00, 0, 0);
        idle(1);
        access(1'b1, 8'h40, 8'h3C, 0, 0);
        idle(2);
        access(1'b0, 8'h40, 8'h00, 0, 0);
        access(1'b0, 8'h12, 8'h00, 0, 2);
        idle(1);
        access(1'b1, 8'h55, 8'h11, 2, 0);
        access(1'b0, 8'h55, 8'h00, 0, 0);
        access(1'b1, 8'h05, 8'h21, 0, 0);
        idle(1);
        reset_mid(8'h05, 8'h77);
        idle(1);
        access(1'b0, 8'h05, 8'h00, 0, 0);

        // Randomized traffic over a small address pool so reads hit written data.
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom_range(1));
            addr = 8'h80 + 8'($urandom_range(15));
            if (!wr && !known[addr]) wr = 1'b1;
            r = ($urandom_range(3) == 0) ? $urandom_range(L, 1) : 0;
            s = ($urandom_range(3) == 0) ? $urandom_range(L + r, 1) : 0;
            access(wr, addr, 8'($urandom_range(255)), r, s);
            idle($urandom_range(2));
        end
        idle(3);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        // LATENCY=1 instance: one-cycle completion, requests issued back to back.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            m1.MStrobe = 1'b1; m1.LdCtr = 1'b1; m1.MRW = w1[i]; m1.MAddr = a1[i]; m1.MDataIn = d1[i];
            @(negedge clk);
            chk("lat1_idle_ctrsig", 32'(m1.CtrSig), 32'd0);
            if (i > 0 && !w1[i-1]) chk("lat1_rdata", 32'(m1.MDataOut), 32'(r1[i-1]));
            @(posedge clk); #1;
            m1.MStrobe = 1'b0; m1.LdCtr = 1'b0;
            @(negedge clk);
            chk("lat1_ctrsig", 32'(m1.CtrSig), 32'd1);
            chk("lat1_busy", 32'(m1.Busy), 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1_rdata_last", 32'(m1.MDataOut), 32'(r1[3]));
        chk("lat1_idle_busy", 32'(m1.Busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
